systemx_sweeper: RTL

//   Upstream stimulus-and-capture stage for the 3-input combinational block systemx.
//   On start, drives A,B,C through all 8 combinations in binary order, holds each for a

---
 rtl/systemx_sweeper.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/systemx_sweeper.sv
// systemx_sweeper: on-chip truth-table sweeper for the 3-input block systemx.
// Walks {a,b,c} through 000..111, holds each vector SETTLE+1 cycles, samples f
// at the end of each hold and compares the captured table with a latched copy
// of exp_tt.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep are held
// RUN   | driving vector idx, counting down the settle time, sampling f
// DONE  | one-cycle result strobe (done=1, busy=1)
module systemx_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] exp_tt,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] exp_q, exp_nx;
    logic [2:0] abc, abc_nx;
    logic       busy_nx, done_nx, pass_nx;
    logic [7:0] tt_nx, tt_smp;
    logic [3:0] err_nx;
    logic [2:0] fail_nx;

    assign a = abc[2];
    assign b = abc[1];
    assign c = abc[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        exp_nx   = exp_q;
        abc_nx   = abc;
        busy_nx  = busy;
        done_nx  = 1'b0;
        pass_nx  = pass;
        tt_nx    = tt;
        err_nx   = err_cnt;
        fail_nx  = fail_idx;
        tt_smp   = tt;
        tt_smp[idx] = f;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = RUN;
                    idx_nx   = 3'd0;
                    abc_nx   = 3'd0;
                    cnt_nx   = SETTLE_C;
                    busy_nx  = 1'b1;
                    tt_nx    = 8'd0;
                    err_nx   = 4'd0;
                    fail_nx  = 3'd0;
                    pass_nx  = 1'b0;
                    exp_nx   = exp_tt;
                end
            end
            RUN: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    tt_nx = tt_smp;
                    if (f != exp_q[idx]) begin
                        err_nx = err_cnt + 4'd1;
                        // err_cnt still zero means this is the sweep's first miss
                        if (err_cnt == 4'd0) fail_nx = idx;
                    end
                    if (idx != 3'd7) begin
                        idx_nx = idx + 3'd1;
                        abc_nx = idx + 3'd1;
                        cnt_nx = SETTLE_C;
                    end else begin
                        state_nx = DONE;
                        abc_nx   = 3'd0;
                        done_nx  = 1'b1;
                        pass_nx  = (tt_smp == exp_q);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 3'd0;
            cnt      <= 4'd0;
            exp_q    <= 8'd0;
            abc      <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            tt       <= 8'd0;
            err_cnt  <= 4'd0;
            fail_idx <= 3'd0;
        end else begin
            idx      <= idx_nx;
            cnt      <= cnt_nx;
            exp_q    <= exp_nx;
            abc      <= abc_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pass     <= pass_nx;
            tt       <= tt_nx;
            err_cnt  <= err_nx;
            fail_idx <= fail_nx;
        end
    end

endmodule
